// File: rtl/edge_seq_pkg.sv
// Shared types and defaults for the edge sequencer: FSM states, sizing defaults
// and the canonical {level, hold} command layout.
package edge_seq_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic                     level;
        logic [DEFAULT_CNT_W-1:0] hold;
    } cmd_t;

endpackage

// File: rtl/edge_seq_fifo.sv
// Command FIFO for the edge sequencer: power-of-two depth, registered occupancy
// count, synchronous flush.
module edge_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/edge_sequencer.sv
// Plays queued {level, hold} commands onto a_o back to back, with registered
// edge pulses, a busy flag and a done pulse when the queue runs dry.
module edge_sequencer
    import edge_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_level_i,
    input  logic [CNT_W-1:0] cmd_hold_i,
    input  logic             abort_i,
    output logic             a_o,
    output logic             rising_o,
    output logic             falling_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             done_q, done_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W:0]   fifo_rdata;
    logic             head_level;
    logic [CNT_W-1:0] head_hold;

    assign cmd_ready_o = !fifo_full;
    assign fifo_push   = cmd_valid_i && cmd_ready_o && !abort_i;
    assign head_level  = fifo_rdata[CNT_W];
    assign head_hold   = fifo_rdata[CNT_W-1:0];

    edge_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CNT_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (abort_i),
        .wdata_i ({cmd_level_i, cmd_hold_i}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // cnt_q holds the cycles remaining after the current one; zero means expire at the next edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end
        if (fifo_pop) begin
            a_d   = head_level;
            cnt_d = (head_hold == '0) ? '0 : head_hold - CNT_W'(1);
        end
        rise_d = a_d && !a_q;
        fall_d = !a_d && a_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            done_q  <= done_d;
        end
    end

    assign a_o       = a_q;
    assign rising_o  = rise_q;
    assign falling_o = fall_q;
    assign busy_o    = (state_q == HOLD);
    assign done_o    = done_q;

endmodule

// File: tb/tb_edge_sequencer.sv
// Self-checking bench for edge_sequencer: directed scenarios plus random traffic
// checked against a queue-and-timestamp reference model.
module tb_edge_sequencer;
    import edge_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_level_i;
    logic [CNT_W-1:0] cmd_hold_i;
    logic             abort_i;
    logic             a_o, rising_o, falling_o, busy_o, done_o;

    int total = 0;
    int bad   = 0;

    // Reference model: pending commands, current level and the absolute cycle it ends.
    int   cyc = 0;
    cmd_t q[$];
    bit   m_active, m_level, m_rise, m_fall, m_done;
    int   m_end;

    always #5 clk = ~clk;

    edge_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_level_i (cmd_level_i),
        .cmd_hold_i  (cmd_hold_i),
        .abort_i     (abort_i),
        .a_o         (a_o),
        .rising_o    (rising_o),
        .falling_o   (falling_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic model_reset();
        q.delete();
        m_active = 1'b0;
        m_level  = 1'b0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_done   = 1'b0;
    endtask

    task automatic start_cmd();
        cmd_t c;
        c        = q.pop_front();
        m_level  = c.level;
        m_end    = cyc + ((c.hold == 0) ? 1 : int'(c.hold));
        m_active = 1'b1;
    endtask

    // Drive one cycle of inputs, advance one clock edge, update the model, settle.
    task automatic step(input bit v, input bit lvl, input int hold, input bit ab);
        bit   ready_pre, prev;
        cmd_t c;
        cmd_valid_i = v;
        cmd_level_i = lvl;
        cmd_hold_i  = CNT_W'(hold);
        abort_i     = ab;
        ready_pre   = (q.size() < DEPTH);
        @(posedge clk);
        cyc++;
        prev   = m_level;
        m_done = 1'b0;
        if (ab) begin
            q.delete();
            m_active = 1'b0;
        end else begin
            if (m_active && cyc == m_end) begin
                if (q.size() > 0) start_cmd();
                else begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (!m_active && q.size() > 0) begin
                start_cmd();
            end
            if (v && ready_pre) begin
                c.level = lvl;
                c.hold  = CNT_W'(hold);
                q.push_back(c);
            end
        end
        m_rise = m_level && !prev;
        m_fall = !m_level && prev;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cmd_valid_i = 1'b0; cmd_level_i = 1'b0; cmd_hold_i = '0; abort_i = 1'b0;
        model_reset();
        #12;
        total++; if (a_o !== 1'b0)         begin bad++; $display("FAIL rst_a_o got=%b exp=0", a_o); end
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cmd_ready_o); end
        total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        total++; if ({rising_o, falling_o, done_o} !== 3'b000)
            begin bad++; $display("FAIL rst_pulses got=%b exp=000", {rising_o, falling_o, done_o}); end
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0);
        total++; if (a_o !== 1'b0)         begin bad++; $display("FAIL post_rst_a_o got=%b exp=0", a_o); end
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", cmd_ready_o); end
        total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL post_rst_busy got=%b exp=0", busy_o); end
        total++; if ({rising_o, falling_o, done_o} !== 3'b000)
            begin bad++; $display("FAIL post_rst_pulses got=%b exp=000", {rising_o, falling_o, done_o}); end
    endtask

    // {1,3} then {0,2}: three high cycles, two low, one of each edge, one done.
    task automatic test_two_levels();
        int hi = 0, lo = 0, nr = 0, nf = 0, nd = 0;
        step(1, 1, 3, 0);
        for (int i = 0; i < 9; i++) begin
            if (i == 0) step(1, 0, 2, 0);
            else        step(0, 0, 0, 0);
            if (busy_o && a_o)  hi++;
            if (busy_o && !a_o) lo++;
            nr += int'(rising_o);
            nf += int'(falling_o);
            nd += int'(done_o);
        end
        total++; if (hi != 3) begin bad++; $display("FAIL two_high_cycles got=%0d exp=3", hi); end
        total++; if (lo != 2) begin bad++; $display("FAIL two_low_cycles got=%0d exp=2", lo); end
        total++; if (nr != 1) begin bad++; $display("FAIL two_rising got=%0d exp=1", nr); end
        total++; if (nf != 1) begin bad++; $display("FAIL two_falling got=%0d exp=1", nf); end
        total++; if (nd != 1) begin bad++; $display("FAIL two_done got=%0d exp=1", nd); end
    endtask

    // {1,0} then {1,5}: hold 0 counts as 1, equal levels merge without pulses.
    task automatic test_merge();
        int hi = 0, nr = 0, nf = 0, nd = 0;
        step(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) step(1, 1, 5, 0);
            else        step(0, 0, 0, 0);
            if (busy_o && a_o) hi++;
            nr += int'(rising_o);
            nf += int'(falling_o);
            nd += int'(done_o);
        end
        total++; if (hi != 6) begin bad++; $display("FAIL merge_high_cycles got=%0d exp=6", hi); end
        total++; if (nr != 1) begin bad++; $display("FAIL merge_rising got=%0d exp=1", nr); end
        total++; if (nf != 0) begin bad++; $display("FAIL merge_falling got=%0d exp=0", nf); end
        total++; if (nd != 1) begin bad++; $display("FAIL merge_done got=%0d exp=1", nd); end
        total++; if (a_o !== 1'b1) begin bad++; $display("FAIL merge_idle_level got=%b exp=1", a_o); end
    endtask

    // Long hold keeps the queue from draining; the fifth command waits for the first pop.
    task automatic test_full();
        int w = 0;
        bit got = 1'b0, acc;
        step(1, 1, 255, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
        total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", cmd_ready_o); end
        while (!got && w < 300) begin
            acc = cmd_ready_o;
            step(1, 0, 1, 0);
            if (acc) got = 1'b1;
            w++;
            total++; if (cmd_ready_o !== (q.size() < DEPTH))
                begin bad++; $display("FAIL full_ready_track got=%b exp=%b", cmd_ready_o, q.size() < DEPTH); end
            total++; if (a_o !== m_level) begin bad++; $display("FAIL full_a_o got=%b exp=%b", a_o, m_level); end
        end
        // Long command popped at edge 2 expires 255 edges later; acceptance follows one edge after.
        total++; if (!got)    begin bad++; $display("FAIL full_accept_timeout waited=%0d", w); end
        total++; if (w != 253) begin bad++; $display("FAIL full_wait_cycles got=%0d exp=253", w); end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0);
            total++; if ({a_o, busy_o, done_o} !== {m_level, m_active, m_done})
                begin bad++; $display("FAIL full_drain got=%b exp=%b", {a_o, busy_o, done_o}, {m_level, m_active, m_done}); end
        end
    endtask

    task automatic test_abort();
        step(1, 1, 10, 0);
        step(1, 0, 2, 0);
        step(1, 1, 3, 0);
        step(0, 0, 0, 0);
        total++; if (a_o !== 1'b1) begin bad++; $display("FAIL abort_pre_a_o got=%b exp=1", a_o); end
        step(1, 0, 1, 1);
        total++; if (a_o !== 1'b1)    begin bad++; $display("FAIL abort_a_o got=%b exp=1", a_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done_o); end
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", cmd_ready_o); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            total++; if ({a_o, busy_o, done_o} !== 3'b100)
                begin bad++; $display("FAIL abort_idle got=%b exp=100", {a_o, busy_o, done_o}); end
        end
    endtask

    task automatic test_async_reset();
        step(1, 1, 4, 0);
        step(1, 0, 3, 0);
        step(0, 0, 0, 0);
        total++; if (a_o !== 1'b1) begin bad++; $display("FAIL arst_pre_a_o got=%b exp=1", a_o); end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (a_o !== 1'b0)         begin bad++; $display("FAIL arst_a_o got=%b exp=0", a_o); end
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", cmd_ready_o); end
        total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL arst_busy got=%b exp=0", busy_o); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0);
            total++; if ({a_o, busy_o} !== 2'b00)
                begin bad++; $display("FAIL arst_empty got=%b exp=00", {a_o, busy_o}); end
        end
        step(1, 1, 2, 0);
        total++; if (a_o !== 1'b0) begin bad++; $display("FAIL arst_cmd_n got=%b exp=0", a_o); end
        step(0, 0, 0, 0);
        total++; if ({a_o, rising_o, busy_o} !== 3'b111)
            begin bad++; $display("FAIL arst_cmd_n1 got=%b exp=111", {a_o, rising_o, busy_o}); end
    endtask

    task automatic test_random();
        bit v, lvl, ab;
        int hold;
        for (int i = 0; i < 600; i++) begin
            v    = ($urandom_range(0, 1) == 1);
            lvl  = ($urandom_range(0, 1) == 1);
            hold = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            ab   = ($urandom_range(0, 31) == 0);
            step(v, lvl, hold, ab);
            total++;
            if ({a_o, rising_o, falling_o, done_o, busy_o, cmd_ready_o} !==
                {m_level, m_rise, m_fall, m_done, m_active, q.size() < DEPTH}) begin
                bad++;
                $display("FAIL rand step=%0d got a/r/f/d/b/rdy=%b exp=%b", i,
                         {a_o, rising_o, falling_o, done_o, busy_o, cmd_ready_o},
                         {m_level, m_rise, m_fall, m_done, m_active, q.size() < DEPTH});
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_levels();
        test_merge();
        test_full();
        test_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
